// File: rtl/pool_max2x2.sv
// 2x2 stride-2 max pooling over a raster pixel stream, all lanes in parallel.
// Each horizontal pair is reduced first; even rows park the pair maximum in a half-width line buffer.
module pool_max2x2 #(
  parameter int DATA_WIDTH = 22,
  parameter int NUM_INPUTS = 4,
  parameter int IMG_WIDTH  = 28,
  parameter int IMG_HEIGHT = 28
) (
  input  logic                                  pool_clk,
  input  logic                                  pool_rst,
  input  logic                                  pool_clear_i,
  input  logic                                  pool_valid_i,
  input  logic [NUM_INPUTS-1:0][DATA_WIDTH-1:0] pool_data_i,
  output logic                                  pool_valid_o,
  output logic [NUM_INPUTS-1:0][DATA_WIDTH-1:0] pool_data_o,
  output logic                                  pool_last_o
);

  localparam int CW    = (IMG_WIDTH > 2) ? $clog2(IMG_WIDTH) : 1;
  localparam int RW    = (IMG_HEIGHT > 2) ? $clog2(IMG_HEIGHT) : 1;
  localparam int DEPTH = IMG_WIDTH / 2;
  localparam int LW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef logic [NUM_INPUTS-1:0][DATA_WIDTH-1:0] pix_t;

  generate
    if ((IMG_WIDTH % 2) != 0 || IMG_WIDTH < 2) begin : g_bad_width
      $error("pool_max2x2: IMG_WIDTH must be even and at least 2");
    end
    if ((IMG_HEIGHT % 2) != 0 || IMG_HEIGHT < 2) begin : g_bad_height
      $error("pool_max2x2: IMG_HEIGHT must be even and at least 2");
    end
  endgenerate

  // Ties keep the first operand; the value is identical either way.
  function automatic logic signed [DATA_WIDTH-1:0] lane_max(
    input logic signed [DATA_WIDTH-1:0] a,
    input logic signed [DATA_WIDTH-1:0] b
  );
    return (b > a) ? b : a;
  endfunction

  function automatic pix_t pix_max(input pix_t a, input pix_t b);
    pix_t m;
    for (int l = 0; l < NUM_INPUTS; l++) begin
      m[l] = lane_max(a[l], b[l]);
    end
    return m;
  endfunction

  logic [CW-1:0] col_p0;
  logic [RW-1:0] row_p0;
  pix_t          pair_p0;
  pix_t          line_buf [DEPTH];

  logic          accept;
  logic          col_last;
  logic          row_last;
  logic [LW-1:0] lb_idx;
  pix_t          hmax;
  pix_t          pool_res;

  logic          vld_p1;
  logic          last_p1;
  pix_t          data_p1;

  assign accept   = pool_valid_i & ~pool_clear_i;
  assign col_last = (col_p0 == CW'(IMG_WIDTH - 1));
  assign row_last = (row_p0 == RW'(IMG_HEIGHT - 1));
  assign lb_idx   = LW'(col_p0 >> 1);

  always_comb begin
    hmax     = pix_max(pair_p0, pool_data_i);
    pool_res = pix_max(line_buf[lb_idx], hmax);
  end

  // Stage p0: raster position, pair register and output register
  always_ff @(posedge pool_clk or posedge pool_rst) begin
    if (pool_rst) begin
      col_p0  <= '0;
      row_p0  <= '0;
      pair_p0 <= '0;
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
      data_p1 <= '0;
    end else if (pool_clear_i) begin
      col_p0  <= '0;
      row_p0  <= '0;
      pair_p0 <= '0;
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
    end else begin
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
      if (accept) begin
        if (!col_p0[0]) begin
          pair_p0 <= pool_data_i;
        end else if (row_p0[0]) begin
          data_p1 <= pool_res;
          vld_p1  <= 1'b1;
          last_p1 <= row_last && col_last;
        end
        if (col_last) begin
          col_p0 <= '0;
          row_p0 <= row_last ? '0 : row_p0 + 1'b1;
        end else begin
          col_p0 <= col_p0 + 1'b1;
        end
      end
    end
  end

  // Line buffer is written only on even rows and read only on odd rows
  always_ff @(posedge pool_clk) begin
    if (accept && col_p0[0] && !row_p0[0]) begin
      line_buf[lb_idx] <= hmax;
    end
  end

  // Stage p1: registered pooled pixel
  assign pool_valid_o = vld_p1;
  assign pool_last_o  = last_p1;
  assign pool_data_o  = data_p1;

endmodule

// File: tb/tb_pool_max2x2.sv
// Bench for pool_max2x2: a 4x4/2-lane/8-bit instance for the directed cases and a default 28x28 instance.
module tb_pool_max2x2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic clr_s = 1'b0, vld_s = 1'b0, clr_b = 1'b0, vld_b = 1'b0;
  logic [1:0][7:0]  din_s = '0, dout_s;
  logic [3:0][21:0] din_b = '0, dout_b;
  logic vo_s, lo_s, vo_b, lo_b;

  pool_max2x2 #(.DATA_WIDTH(8), .NUM_INPUTS(2), .IMG_WIDTH(4), .IMG_HEIGHT(4)) u_small (
    .pool_clk(clk), .pool_rst(rst), .pool_clear_i(clr_s), .pool_valid_i(vld_s),
    .pool_data_i(din_s), .pool_valid_o(vo_s), .pool_data_o(dout_s), .pool_last_o(lo_s)
  );

  pool_max2x2 u_big (
    .pool_clk(clk), .pool_rst(rst), .pool_clear_i(clr_b), .pool_valid_i(vld_b),
    .pool_data_i(din_b), .pool_valid_o(vo_b), .pool_data_o(dout_b), .pool_last_o(lo_b)
  );

  typedef struct { int lane[4]; logic last; int unsigned due; } exp_t;
  typedef struct { int lane[4]; logic last; } cap_t;
  typedef struct { int l0; int l1; logic last; } ref_t;
  typedef struct { int w[4]; int expv; } win_t;

  exp_t q_s[$];
  exp_t q_b[$];
  cap_t cap_s[$];
  int   frame [2][28][28][4];
  int   rr[2];
  int   cc[2];
  int   errors = 0;
  int   checks = 0;
  int   nout_b = 0;
  int   nlast_b = 0;
  int unsigned cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", nm, act, req);
    end
  endtask

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Reference: remember the frame; at each window's bottom-right pixel take the max of its four pixels.
  task automatic model_accept(input int sel, input int lanes[4]);
    int w, h, n, r, c;
    exp_t e;
    w = sel ? 28 : 4;
    h = sel ? 28 : 4;
    n = sel ? 4 : 2;
    r = rr[sel];
    c = cc[sel];
    for (int l = 0; l < 4; l++) frame[sel][r][c][l] = lanes[l];
    if ((r % 2 == 1) && (c % 2 == 1)) begin
      for (int l = 0; l < 4; l++) begin
        e.lane[l] = (l < n) ? max2(max2(frame[sel][r-1][c-1][l], frame[sel][r-1][c][l]),
                                   max2(frame[sel][r][c-1][l], frame[sel][r][c][l])) : 0;
      end
      e.last = (r == h - 1) && (c == w - 1);
      e.due  = cyc + 1;
      if (sel == 0) q_s.push_back(e);
      else          q_b.push_back(e);
    end
    cc[sel] = (c + 1) % w;
    if (c == w - 1) rr[sel] = (r + 1) % h;
  endtask

  task automatic drive(input int sel, input int lanes[4], input logic v, input logic clr);
    if (sel == 0) begin
      vld_s = v; clr_s = clr;
      for (int l = 0; l < 2; l++) din_s[l] = 8'(lanes[l]);
    end else begin
      vld_b = v; clr_b = clr;
      for (int l = 0; l < 4; l++) din_b[l] = 22'(lanes[l]);
    end
    if (clr) begin
      rr[sel] = 0;
      cc[sel] = 0;
    end else if (v) begin
      model_accept(sel, lanes);
    end
    @(posedge clk); #1;
    vld_s = 1'b0; clr_s = 1'b0; vld_b = 1'b0; clr_b = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_small(input int a, input int b, input int gap_max);
    int lanes[4];
    lanes[0] = a; lanes[1] = b; lanes[2] = 0; lanes[3] = 0;
    drive(0, lanes, 1'b1, 1'b0);
    if (gap_max > 0) idle($urandom_range(0, gap_max));
  endtask

  task automatic mon(input int sel, input logic vo, input logic lo, input int got[4]);
    exp_t e;
    int n;
    n = sel ? 4 : 2;
    if (vo) begin
      if ((sel == 0 && q_s.size() == 0) || (sel == 1 && q_b.size() == 0)) begin
        checks++; errors++;
        $display("FAIL unexpected_out%0d: got valid at cycle %0d, required no output", sel, cyc);
      end else begin
        if (sel == 0) e = q_s.pop_front();
        else          e = q_b.pop_front();
        check($sformatf("latency%0d", sel), cyc, e.due);
        for (int l = 0; l < n; l++) check($sformatf("data%0d_lane%0d", sel, l), got[l], e.lane[l]);
        check($sformatf("last%0d", sel), lo, e.last);
        if (sel == 0) begin
          cap_t cp;
          cp.lane = got;
          cp.last = lo;
          cap_s.push_back(cp);
        end else begin
          nout_b++;
          if (lo) nlast_b++;
        end
      end
    end else begin
      if (lo) begin
        checks++; errors++;
        $display("FAIL last_without_valid%0d: got last=1, required 0", sel);
      end
      if (sel == 0 && q_s.size() > 0 && q_s[0].due <= cyc) begin
        e = q_s.pop_front();
        checks++; errors++;
        $display("FAIL missing_out0: got no valid at cycle %0d, required valid at %0d", cyc, e.due);
      end
      if (sel == 1 && q_b.size() > 0 && q_b[0].due <= cyc) begin
        e = q_b.pop_front();
        checks++; errors++;
        $display("FAIL missing_out1: got no valid at cycle %0d, required valid at %0d", cyc, e.due);
      end
    end
  endtask

  always @(negedge clk) begin : monitor
    int gs[4];
    int gb[4];
    if (!rst) begin
      for (int l = 0; l < 4; l++) begin
        gs[l] = 0;
        gb[l] = int'($signed(dout_b[l]));
      end
      for (int l = 0; l < 2; l++) gs[l] = int'($signed(dout_s[l]));
      mon(0, vo_s, lo_s, gs);
      mon(1, vo_b, lo_b, gb);
    end
  end

  ref_t ref_tab[4];
  win_t win_tab[3];

  task automatic check_basic(input string tag);
    check({tag, "_count"}, cap_s.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < cap_s.size()) begin
        check($sformatf("%s_l0_%0d", tag, i), cap_s[i].lane[0], ref_tab[i].l0);
        check($sformatf("%s_l1_%0d", tag, i), cap_s[i].lane[1], ref_tab[i].l1);
        check($sformatf("%s_last_%0d", tag, i), cap_s[i].last, ref_tab[i].last);
      end
    end
    cap_s.delete();
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_valid_s"}, vo_s, 0);
    check({tag, "_last_s"}, lo_s, 0);
    check({tag, "_data_s"}, dout_s, 0);
    check({tag, "_valid_b"}, vo_b, 0);
    check({tag, "_last_b"}, lo_b, 0);
    check({tag, "_data_b"}, (dout_b == '0) ? 0 : 1, 0);
  endtask

  initial begin
    int lanes[4];
    logic [21:0] t;

    ref_tab[0] = '{l0: 5,  l1: 15, last: 1'b0};
    ref_tab[1] = '{l0: 7,  l1: 13, last: 1'b0};
    ref_tab[2] = '{l0: 13, l1: 7,  last: 1'b0};
    ref_tab[3] = '{l0: 15, l1: 5,  last: 1'b1};
    win_tab[0] = '{w: '{-3, -1, -8, -2},    expv: -1};
    win_tab[1] = '{w: '{-128, 127, 0, -1},  expv: 127};
    win_tab[2] = '{w: '{-5, -5, -5, -5},    expv: -5};
    rr[0] = 0; rr[1] = 0; cc[0] = 0; cc[1] = 0;

    // power-on reset state
    idle(3);
    check_zero_outputs("reset");
    rst = 1'b0;
    idle(2);

    // ramp frame, consecutive beats
    for (int i = 0; i < 16; i++) send_small(i, 15 - i, 0);
    idle(3);
    check_basic("ramp");

    // ramp frame with random gaps
    for (int i = 0; i < 16; i++) send_small(i, 15 - i, 3);
    idle(3);
    check_basic("gaps");

    // signed windows in the top-left window of lane 0
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 16; i++) begin
        int v;
        v = 0;
        if (i == 0) v = win_tab[k].w[0];
        if (i == 1) v = win_tab[k].w[1];
        if (i == 4) v = win_tab[k].w[2];
        if (i == 5) v = win_tab[k].w[3];
        send_small(v, (i * 37) % 256 - 128, 0);
      end
      idle(3);
      check($sformatf("signed_count_%0d", k), cap_s.size(), 4);
      if (cap_s.size() > 0) check($sformatf("signed_win_%0d", k), cap_s[0].lane[0], win_tab[k].expv);
      cap_s.delete();
    end

    // two back-to-back random 28x28 frames
    for (int i = 0; i < 2 * 28 * 28; i++) begin
      for (int l = 0; l < 4; l++) begin
        t = 22'($urandom);
        lanes[l] = int'($signed(t));
      end
      drive(1, lanes, 1'b1, 1'b0);
    end
    idle(3);
    check("big_outputs", nout_b, 392);
    check("big_last_count", nlast_b, 2);

    // async reset during beat 10 of a small frame
    for (int i = 0; i < 10; i++) send_small(i, 15 - i, 0);
    idle(1);
    cap_s.delete();
    vld_s = 1'b1;
    din_s[0] = 8'd10;
    din_s[1] = 8'd5;
    rst = 1'b1;
    q_s.delete(); q_b.delete();
    rr[0] = 0; rr[1] = 0; cc[0] = 0; cc[1] = 0;
    @(posedge clk); #1;
    vld_s = 1'b0;
    check_zero_outputs("midreset");
    rst = 1'b0;
    idle(1);
    for (int i = 0; i < 16; i++) send_small(i, 15 - i, 0);
    idle(3);
    check_basic("after_reset");

    // clear with a valid beat at beat 6
    for (int i = 0; i < 6; i++) send_small(i, 15 - i, 0);
    lanes[0] = 6; lanes[1] = 9; lanes[2] = 0; lanes[3] = 0;
    drive(0, lanes, 1'b1, 1'b1);
    idle(2);
    check("clear_no_output", vo_s, 0);
    cap_s.delete();
    for (int i = 0; i < 16; i++) send_small(i, 15 - i, 0);
    idle(3);
    check_basic("after_clear");

    check("pending_small", q_s.size(), 0);
    check("pending_big", q_b.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
